shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request to begin one shift operation.
REQ-004 SHALL have port in, input, 32, operand, treated as signed for arithmetic shifts.
REQ-005 SHALL have port shamt, input, 32, shift amount, full 32-bit unsigned value.
REQ-006 SHALL have port left_shift, input, 1, 1 = left, 0 = right.
REQ-007 SHALL have port arithmetic_shift, input, 1, 1 = arithmetic, 0 = logical.
REQ-008 SHALL have port out, output, 32, registered result of the last completed operation.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse, high only in state DONE.

Function
REQ-011 SHALL implement a serial shifter, one bit position per clock, with states IDLE, SHIFT and DONE.
REQ-012 SHALL accept start only in IDLE, and SHALL ignore start in SHIFT and DONE (no queuing).
REQ-013 On the accepting edge E0, SHALL latch in, left_shift and arithmetic_shift, and load count k = min(shamt, 32) (6-bit counter); later operand changes SHALL have no effect.
REQ-014 Arithmetic with left_shift = 1 SHALL be a pass-through: result = in, and k is forced to 0.
REQ-015 If k = 0, E0 SHALL go IDLE -> DONE directly; otherwise IDLE -> SHIFT.
REQ-016 In SHIFT, each edge SHALL shift the working register one bit and decrement count:
- left: fill 0
- logical right: fill 0
- arithmetic right: fill with the latched bit 31
REQ-017 The edge on which count reaches 0 SHALL move SHIFT -> DONE, so DONE is entered on edge E(k) and done is high in the cycle following E(k).
REQ-018 out SHALL update only on the edge entering DONE, and SHALL hold its value through IDLE and later SHIFT cycles until the next DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 A new start SHALL be accepted in the cycle after DONE at the earliest.
REQ-021 Results SHALL equal the combinational shift: in << k, in >> k, or in >>> k; for k = 32 the result is 0 (left or logical right) or 32 copies of bit 31 (arithmetic right).
REQ-022 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-023 There SHALL be no combinational path from any input to out, busy or done.

Reset
REQ-024 While rst is high at an edge, SHALL set state = IDLE, out = 0, count = 0 and working register = 0, with busy = 0 and done = 0; rst has priority over start.
REQ-025 rst during SHIFT or DONE SHALL abort the operation: no done pulse, and out = 0.
REQ-026 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-027 in=0x000000F0, shamt=4, left=1, arith=0 -> busy from E0; done at E4; out=0x00000F00.
REQ-028 in=0x80000000, shamt=31, left=0, arith=1 -> done at E31; out=0xFFFFFFFF. Same with arith=0 -> out=0x00000001.
REQ-029 in=0x12345678, shamt=0, logical right -> done at E0 (cycle after start); out=0x12345678. Then in=0xFFFFFFFF, shamt=40, left -> k=32, done at E32, out=0x00000000.
REQ-030 in=0xDEADBEEF, shamt=5, left=1, arith=1 -> done at E0; out=0xDEADBEEF.
REQ-031 Start with shamt=10. Pulse start with different operands at E3 and on the DONE cycle -> both ignored; only one done at E10, with the result for the first operands.
REQ-032 Complete one op leaving out=0x00000F00, then start shamt=20 and assert rst at E5 -> busy=0, done never pulses, out=0. Next start, shamt=1, in=1, left -> out=2 at E1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Serial shifter: moves the latched operand one bit position per clock.
// Shift direction and kind (logical / arithmetic) are captured with the
// operand when the operation starts. The shift amount saturates at 32.
// A one-cycle done pulse marks the cycle in which out holds the new result.
//
// Handshake: start is sampled only while idle (busy low). Once accepted,
// busy stays high through SHIFT and DONE, and any start seen in those
// states is dropped. done is high for exactly one cycle, and out is valid
// from that cycle until the next done. The earliest next start is in the
// cycle after done.
module shift_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in,
   input  logic [31:0] shamt,
   input  logic        left_shift,
   input  logic        arithmetic_shift,
   output logic [31:0] out,
   output logic        busy,
   output logic        done,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  count;
   logic [31:0] work;
   logic        left_q;
   logic        arith_q;
   logic        sign_q;

   logic [5:0]  load_k;
   logic [31:0] shift_next;

   // Saturate the shift amount at 32. Arithmetic left is a pass-through, so its count is zero.
   always_comb begin
      load_k = 6'd0;
      if ((|shamt[31:6]) || (shamt[5:0] > 6'd32)) begin
         load_k = 6'd32;
      end else begin
         load_k = shamt[5:0];
      end
      if (arithmetic_shift && left_shift) begin
         load_k = 6'd0;
      end
   end

   // Shift the working register one position. An arithmetic right shift fills with the latched sign.
   always_comb begin
      shift_next = work;
      if (left_q) begin
         shift_next = {work[30:0], 1'b0};
      end else begin
         shift_next = {(arith_q & sign_q), work[31:1]};
      end
   end

   // Sequencer state, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= 6'd0;
         work    <= 32'd0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
         sign_q  <= 1'b0;
         out     <= 32'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  work    <= in;
                  left_q  <= left_shift;
                  arith_q <= arithmetic_shift;
                  sign_q  <= in[31];
                  count   <= load_k;
                  busy    <= 1'b1;
                  if (load_k == 6'd0) begin
                     // Nothing to shift: the operand is the result.
                     state <= DONE;
                     out   <= in;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= shift_next;
               count <= count - 6'd1;
               if (count == 6'd1) begin
                  // This edge does the final shift, so publish its value directly.
                  state <= DONE;
                  out   <= shift_next;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. Directed cases plus randomized operations
// are compared against a reference model that uses plain shift arithmetic.
module tb_shift_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] in;
   logic [31:0] shamt;
   logic        left_shift;
   logic        arithmetic_shift;
   logic [31:0] out;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   shift_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .in               (in),
      .shamt            (shamt),
      .left_shift       (left_shift),
      .arithmetic_shift (arithmetic_shift),
      .out              (out),
      .busy             (busy),
      .done             (done),
      .dbg_state        (dbg_state)
   );

   // clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] last_out;
   int          busy_from;
   int          busy_to;
   bit          mon_en;
   int          checks = 0;
   int          errors = 0;

   // reference model: the result of the combinational shift
   function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [31:0] s,
                                              input logic l, input logic a, output int k);
      int kk;
      kk = (s > 32'd32) ? 32 : int'(s);
      if (l && a) begin
         k = 0;
         return d;
      end
      k = kk;
      if (l) return (kk == 32) ? 32'd0 : (d << kk);
      if (!a) return (kk == 32) ? 32'd0 : (d >> kk);
      return (kk == 32) ? {32{d[31]}} : 32'($signed(d) >>> kk);
   endfunction

   // driver: issue one operation; returns at E0 + 1 time unit
   task automatic run_op(input logic [31:0] d, input logic [31:0] s,
                         input logic l, input logic a, output int k);
      logic [31:0] r;
      r = ref_result(d, s, l, a, k);
      in               = d;
      shamt            = s;
      left_shift       = l;
      arithmetic_shift = a;
      start            = 1'b1;
      @(posedge clk);
      #1;
      start            = 1'b0;
      // operand changes after acceptance must have no effect
      in               = $urandom;
      shamt            = $urandom;
      left_shift       = 1'($urandom_range(0, 1));
      arithmetic_shift = 1'($urandom_range(0, 1));
      exp_q.push_back(r);
      exp_cyc_q.push_back(cyc + k);
      busy_from = cyc;
      busy_to   = cyc + k;
   endtask

   // driver: wait until the operation has left DONE
   task automatic finish_op(input int k);
      repeat (k + 1) @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [31:0] d, input logic [31:0] s,
                        input logic l, input logic a);
      int k;
      run_op(d, s, l, a, k);
      finish_op(k);
   endtask

   // monitor: pop and compare whenever done is presented
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_busy;
         if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
            checks++;
            errors++;
            $display("FAIL missing_done cyc=%0d expected_at=%0d", cyc, exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
         exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
         end
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done cyc=%0d out=%08h", cyc, out);
            end else begin
               logic [31:0] e;
               int          c;
               e = exp_q.pop_front();
               c = exp_cyc_q.pop_front();
               checks++;
               if (cyc != c) begin
                  errors++;
                  $display("FAIL done_time got_cyc=%0d exp_cyc=%0d", cyc, c);
               end
               checks++;
               if (out !== e) begin
                  errors++;
                  $display("FAIL result got=%08h exp=%08h", out, e);
               end
               last_out = e;
            end
         end else begin
            checks++;
            if (out !== last_out) begin
               errors++;
               $display("FAIL out_hold cyc=%0d got=%08h exp=%08h", cyc, out, last_out);
            end
            checks++;
            if (done !== 1'b0) begin
               errors++;
               $display("FAIL done_level cyc=%0d got=%b exp=0", cyc, done);
            end
         end
      end
   end

   // stimulus
   initial begin
      int k;
      mon_en           = 1'b0;
      last_out         = 32'd0;
      busy_from        = 0;
      busy_to          = -1;
      rst              = 1'b1;
      start            = 1'b0;
      in               = 32'd0;
      shamt            = 32'd0;
      left_shift       = 1'b0;
      arithmetic_shift = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state out=%08h busy=%b done=%b exp=0/0/0", out, busy, done);
      end
      rst    = 1'b0;
      mon_en = 1'b1;

      // directed cases; the first start lands on the first edge after reset
      do_op(32'h000000F0, 32'd4,  1'b1, 1'b0);
      do_op(32'h80000000, 32'd31, 1'b0, 1'b1);
      do_op(32'h80000000, 32'd31, 1'b0, 1'b0);
      do_op(32'h12345678, 32'd0,  1'b0, 1'b0);
      do_op(32'hFFFFFFFF, 32'd40, 1'b1, 1'b0);
      do_op(32'hDEADBEEF, 32'd5,  1'b1, 1'b1);
      do_op(32'h80000001, 32'd32, 1'b0, 1'b1);
      do_op(32'h80000001, 32'hFFFFFFFF, 1'b0, 1'b0);

      // starts during SHIFT and during DONE are ignored
      run_op(32'h0000ABCD, 32'd10, 1'b1, 1'b0, k);
      repeat (2) @(posedge clk);
      #1;
      in = 32'h11111111; shamt = 32'd1; left_shift = 1'b0; arithmetic_shift = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      in = 32'h22222222; shamt = 32'd0; left_shift = 1'b0; arithmetic_shift = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // reset in the middle of an operation aborts it
      do_op(32'h000000F0, 32'd4, 1'b1, 1'b0);
      run_op(32'h0F0F0F0F, 32'd20, 1'b1, 1'b0, k);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      last_out = 32'd0;
      busy_to  = -1;
      do_op(32'h00000001, 32'd1, 1'b1, 1'b0);

      // randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [31:0] s;
         case ($urandom_range(0, 4))
            0:       s = 32'($urandom_range(0, 33));
            1:       s = 32'($urandom_range(30, 33));
            2:       s = $urandom;
            3:       s = 32'($urandom_range(0, 3));
            default: s = 32'($urandom_range(4, 31));
         endcase
         do_op($urandom, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
